shader_instr_sequencer: RTL and testbench

//  Holds the shader program (NUM_INSTR x INSTR_W) loaded byte-by-byte from the SPI receiver.

---
 rtl/shader_instr_sequencer.sv | 137 +++++++++++++
 tb/tb_shader_instr_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_instr_sequencer.sv
// Shader program store with a one-entry load buffer, replayed per start pulse over valid/ready.
// Optional build macro SHADER_SEQ_SKIP_NOP_EN: NOP_OPCODE slots are stepped over without a handshake.
module shader_instr_sequencer #(
  parameter int NUM_INSTR = 8,
  parameter int INSTR_W = 8,
  parameter logic [INSTR_W-1:0] NOP_OPCODE = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_instr_i,
  input  logic               start_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               instr_last_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               start_miss_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i
);

  localparam int PC_W = $clog2(NUM_INSTR);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_INSTR - 1);

`ifdef SHADER_SEQ_SKIP_NOP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] mem_q [NUM_INSTR];
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] pend_q;
  logic               pend_vld_q;
  logic               done_q;
  logic               miss_q;
  logic               ovf_q;

  logic run;
  logic pc_last;
  logic skip_nop;
  logic advance;
  logic commit;
  logic drop;

  assign run      = (state_q == RUN);
  assign pc_last  = (pc_q == PC_LAST);
  assign skip_nop = SKIP_EN && run && (mem_q[pc_q] == NOP_OPCODE);
  // Start wins over a waiting commit so the run sees the old program.
  assign commit   = !run && !start_i && pend_vld_q;
  assign drop     = load_i && pend_vld_q && !commit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (advance && pc_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_o       = mem_q[pc_q];
    instr_valid_o = run && !skip_nop;
    instr_last_o  = run && pc_last;
    busy_o        = run;
    advance       = skip_nop || (instr_valid_o && instr_ready_i);
    done_o        = done_q;
    start_miss_o  = miss_q;
    overflow_o    = ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else if (!run && start_i) begin
      pc_q <= '0;
    end else if (advance) begin
      pc_q <= pc_last ? '0 : pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (load_i && (!pend_vld_q || commit)) begin
      pend_q     <= load_instr_i;
      pend_vld_q <= 1'b1;
    end else if (commit) begin
      pend_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_INSTR; i++) mem_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_INSTR - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[NUM_INSTR-1] <= pend_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      miss_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= run && advance && pc_last;
      miss_q <= run && start_i;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shader_instr_sequencer.sv
// Directed bench for shader_instr_sequencer.
// Expected values follow SHADER_SEQ_SKIP_NOP_EN when that build is selected.
module tb_shader_instr_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       load_i;
  logic [7:0] load_instr_i;
  logic       start_i;
  logic [7:0] instr_o;
  logic       instr_valid_o;
  logic       instr_ready_i;
  logic       instr_last_o;
  logic       done_o;
  logic       busy_o;
  logic       start_miss_o;
  logic       overflow_o;
  logic       clr_overflow_i;

  int errors = 0;
  int checks = 0;
  logic [7:0] prog [8];

  shader_instr_sequencer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_i        (load_i),
    .load_instr_i  (load_instr_i),
    .start_i       (start_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_last_o  (instr_last_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .start_miss_o  (start_miss_o),
    .overflow_o    (overflow_o),
    .clr_overflow_i(clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 8; i++) begin
      load_i = 1'b1;
      load_instr_i = prog[i];
      tick();
    end
    load_i = 1'b0;
    tick();
    checks++;
    if (instr_o !== prog[0]) begin
      errors++;
      $display("FAIL load_mem0: got %h want %h", instr_o, prog[0]);
    end
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst_ni = 1'b0;
    load_i = 1'b0;
    load_instr_i = '0;
    start_i = 1'b0;
    instr_ready_i = 1'b0;
    clr_overflow_i = 1'b0;
    #12;
    outs = {instr_o, instr_valid_o, instr_last_o, done_o,
            busy_o, start_miss_o, overflow_o};
    checks++;
    if (outs !== 14'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0000", outs);
    end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load_prog();
    instr_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (!instr_valid_o || instr_o !== prog[i] ||
          instr_last_o !== (i == 7) || !busy_o) begin
        errors++;
        $display("FAIL basic_%0d: got v=%b i=%h l=%b want v=1 i=%h l=%b",
                 i, instr_valid_o, instr_o, instr_last_o, prog[i], i == 7);
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b want 1 0", done_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b want 0", done_o);
    end
  endtask

  task automatic test_ready_toggle();
    logic rdy [11];
    int k;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    k = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 11 && k < 8; c++) begin
      instr_ready_i = rdy[c];
      checks++;
      if (!instr_valid_o || instr_o !== prog[k]) begin
        errors++;
        $display("FAIL hold_c%0d: got v=%b i=%h want v=1 i=%h",
                 c, instr_valid_o, instr_o, prog[k]);
      end
      tick();
      if (rdy[c]) k++;
    end
    instr_ready_i = 1'b1;
    checks++;
    if (k != 8 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_done: got k=%0d done=%b want 8 1", k, done_o);
    end
    tick();
  endtask

  task automatic test_overflow();
    instr_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    load_i = 1'b1;
    load_instr_i = 8'hAA;
    tick();
    load_instr_i = 8'hBB;
    tick();
    load_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b want 1", overflow_o);
    end
    for (int i = 2; i < 8; i++) begin
      checks++;
      if (instr_o !== prog[i] || !instr_valid_o) begin
        errors++;
        $display("FAIL ovf_run_%0d: got %h want %h", i, instr_o, prog[i]);
      end
      tick();
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done: got %b want 1", done_o);
    end
    tick();
    checks++;
    if (instr_o !== 8'h02 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_commit: got %h ovf=%b want 02 1", instr_o, overflow_o);
    end
    clr_overflow_i = 1'b1;
    tick();
    clr_overflow_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", overflow_o);
    end
  endtask

  task automatic test_start_commit();
    prog = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    load_i = 1'b1;
    load_instr_i = 8'hCC;
    tick();
    load_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (!instr_valid_o || instr_o !== prog[i]) begin
        errors++;
        $display("FAIL sc_run_%0d: got v=%b i=%h want v=1 i=%h",
                 i, instr_valid_o, instr_o, prog[i]);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (start_miss_o !== (i == 4)) begin
          errors++;
          $display("FAIL sc_miss_%0d: got %b want %b", i, start_miss_o, i == 4);
        end
      end
      start_i = (i == 3);
      tick();
      start_i = 1'b0;
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL sc_done: got done=%b busy=%b want 1 0", done_o, busy_o);
    end
    tick();
    checks++;
    if (instr_o !== 8'h03 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL sc_commit: got %h busy=%b want 03 0", instr_o, busy_o);
    end
  endtask

  task automatic test_nop();
    logic [7:0] got [8];
    logic [7:0] want [8];
    int n;
    int want_n;
    bit seen_done;
    prog = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h33};
`ifdef SHADER_SEQ_SKIP_NOP_EN
    want = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    want_n = 3;
`else
    want = prog;
    want_n = 8;
`endif
    load_prog();
    n = 0;
    seen_done = 1'b0;
    instr_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (done_o) begin
        seen_done = 1'b1;
      end else begin
        if (instr_valid_o && n < 8) begin
          got[n] = instr_o;
          n++;
        end
        tick();
      end
    end
    checks++;
    if (!seen_done || n != want_n) begin
      errors++;
      $display("FAIL nop_count: got n=%0d done=%b want n=%0d done=1",
               n, seen_done, want_n);
    end
    for (int i = 0; i < want_n && i < n; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL nop_item_%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    instr_ready_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", busy_o);
    end
    load_i = 1'b1;
    load_instr_i = 8'h5A;
    tick();
    load_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: got busy=%b v=%b i=%h want 0 0 00",
               busy_o, instr_valid_o, instr_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || instr_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_after: got done=%b busy=%b i=%h want 0 0 00",
               done_o, busy_o, instr_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_overflow();
    test_start_commit();
    test_nop();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
